mod_counter: RTL



---
 rtl/counter_pkg.sv | 13 +
 rtl/dff.sv | 16 +
 rtl/reg_n.sv | 22 ++
 rtl/mod_counter.sv | 99 +++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the modular counter family: saturation modes and the
// effective-modulus helper used to size bound comparisons.
package counter_pkg;

  localparam bit SAT_WRAP = 1'b0;
  localparam bit SAT_SAT  = 1'b1;

  // A modulus of 0 selects the full binary range of the counter.
  function automatic longint unsigned eff_mod(input int width, input longint unsigned mod);
    return (mod == 0) ? (64'd1 << width) : mod;
  endfunction

endpackage

// File: rtl/dff.sv
// Single-bit D flip-flop with synchronous active-high reset to a per-bit value.
module dff (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) q <= rst_val;
    else     q <= d;
  end

endmodule

// File: rtl/reg_n.sv
// WIDTH-bit synchronous-reset register bank assembled from dff cells.
module reg_n #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff u_dff (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[i]),
      .d       (d[i]),
      .q       (q[i])
    );
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down modular counter with variable step, wrap or saturate at
// the bounds, and one-cycle terminal (tc) and rejected-request (err) pulses.
module mod_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH   = 16,
  parameter longint unsigned MOD     = 0,
  parameter int              STEP_W  = 4,
  parameter bit              SAT     = SAT_WRAP,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [0:WIDTH-1]  load_data,
  input  logic              up,
  input  logic [0:STEP_W-1] step,
  output logic [0:WIDTH-1]  out,
  output logic              tc,
  output logic              err
);

  localparam int             XW     = WIDTH + 1;
  localparam int             CW     = (STEP_W > XW) ? STEP_W : XW;
  localparam logic [XW-1:0]  M      = XW'(eff_mod(WIDTH, MOD));
  localparam logic [XW-1:0]  M_LAST = M - XW'(1);

  logic [WIDTH-1:0] out_q, next_out;
  logic             next_tc, next_err;
  logic [XW-1:0]    cur, ld_x, step_n, sum, dn_wrap;
  logic [CW-1:0]    step_x, m_x;

  // All arithmetic is one bit wider than the count so out+step and out+M never truncate.
  assign cur     = {1'b0, out_q};
  assign ld_x    = {1'b0, load_data};
  assign step_x  = CW'(step);
  assign m_x     = CW'(M);
  assign step_n  = XW'(step_x);
  assign sum     = cur + step_n;
  assign dn_wrap = cur + M - step_n;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_out = out_q;
    next_tc  = 1'b0;
    next_err = 1'b0;
    if (load) begin
      if (ld_x < M) begin
        next_out = load_data;
      end else begin
        next_out = M_LAST[WIDTH-1:0];
        next_err = 1'b1;
      end
    end else if (en && step_x != '0) begin
      if (step_x >= m_x) begin
        next_err = 1'b1;
      end else if (up) begin
        if (sum < M_LAST) begin
          next_out = sum[WIDTH-1:0];
        end else begin
          // Landing exactly on M-1 counts as reaching the bound.
          next_tc  = 1'b1;
          next_out = (sum == M_LAST || SAT) ? M_LAST[WIDTH-1:0] : WIDTH'(sum - M);
        end
      end else begin
        if (cur > step_n) begin
          next_out = WIDTH'(cur - step_n);
        end else begin
          next_tc  = 1'b1;
          next_out = (cur == step_n || SAT) ? '0 : dn_wrap[WIDTH-1:0];
        end
      end
    end
  end

  reg_n #(
    .WIDTH   (WIDTH),
    .RST_VAL (WIDTH'(RST_VAL))
  ) u_count (
    .clk (clk),
    .rst (rst),
    .d   (next_out),
    .q   (out_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tc  <= 1'b0;
      err <= 1'b0;
    end else begin
      tc  <= next_tc;
      err <= next_err;
    end
  end

  assign out = out_q;

endmodule
